// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that owns the select of an 8:1 one-bit multiplexer
// shared by eight requesting channels. It produces a registered one-hot grant,
// the matching 3-bit mux select and a busy flag.
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN
//   When defined, one requester can hold the mux for at most HOLD_MAX
//   consecutive cycles. It is then forced to re-arbitrate, and a one-cycle
//   timeout pulse is raised. When undefined, a grant lasts until the owner
//   drops its request, hold_cnt does not exist and timeout stays at 0.

module mux_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] select,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [2:0] ptr;

    logic       found;
    logic [2:0] win_idx;
    logic [7:0] win_onehot;
    logic       release_ev;
    logic       revoke;
    logic       take_new;
    logic       go_idle;

    // Reject a hold limit outside 1..256 when the design is elaborated.
    if (HOLD_MAX < 1 || HOLD_MAX > 256) begin : g_hold_range
        $error("mux_rr_arbiter: HOLD_MAX must be in 1..256");
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    logic [CNT_W-1:0] hold_cnt;

    // The owner hits the limit when it has held the mux for HOLD_MAX cycles
    // and still requests it.
    assign revoke = (state == GRANT) && req[select]
                    && (hold_cnt == CNT_W'(HOLD_MAX - 1));

    // Count the cycles of the current tenure. Any new grant restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (take_new) begin
            hold_cnt <= '0;
        end else if (state == GRANT && !go_idle) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end
`else
    assign revoke = 1'b0;
`endif

    // Rotating priority search that starts just after the last owner. The
    // search checks the last owner itself last. ptr always equals select
    // while a grant is held, so one search also serves release and revoke.
    always_comb begin
        found   = 1'b0;
        win_idx = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && req[ptr + 3'(k)]) begin
                found   = 1'b1;
                win_idx = ptr + 3'(k);
            end
        end
        win_onehot = 8'h01 << win_idx;
    end

    // Decide what happens at the coming edge. A release takes precedence
    // over the hold limit because revoke requires req[select] = 1.
    always_comb begin
        release_ev = (state == GRANT) && !req[select];
        take_new   = ((state == IDLE) || release_ev || revoke) && found;
        go_idle    = release_ev && !found;
    end

    // Arbiter FSM with all outputs registered. A handover replaces the old
    // grant with the new one at a single edge, so two grant bits are never set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 8'h00;
            select  <= 3'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= 3'd7;
        end else begin
            timeout <= revoke;
            if (take_new) begin
                state  <= GRANT;
                grant  <= win_onehot;
                select <= win_idx;
                busy   <= 1'b1;
                ptr    <= win_idx;
            end else if (go_idle) begin
                state <= IDLE;
                grant <= 8'h00;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter.
// A table of directed vectors and a few hand-written corner sequences run
// first. Randomised requests then run against a behavioural model of owner
// and tenure. Build with MUX_ARB_TIMEOUT_EN defined to exercise the hold limit.

module tb_mux_rr_arbiter;

    localparam int HOLD_MAX = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] select;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: who owns the mux, how long it has owned it, and the
    // last index that was granted.
    int         m_owner;
    int         m_last;
    int         m_tenure;
    logic [2:0] m_sel;
    logic       m_timeout;

    typedef struct {
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t vecs[26];

    mux_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .select  (select),
        .busy    (busy),
        .timeout (timeout)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Stop a runaway simulation.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        m_owner   = -1;
        m_last    = 7;
        m_tenure  = 0;
        m_sel     = 3'd0;
        m_timeout = 1'b0;
    endfunction

    // Return the first requester after index 'after', going round the ring.
    function automatic int pick(input logic [7:0] r, input int after);
        for (int k = 1; k <= 8; k++) begin
            if (r[(after + k) % 8]) return (after + k) % 8;
        end
        return -1;
    endfunction

    function automatic void take(input int w);
        m_owner  = w;
        m_last   = w;
        m_sel    = 3'(w);
        m_tenure = 1;
    endfunction

    function automatic void model_step(input logic [7:0] r);
        int w;
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_last);
            if (w >= 0) take(w);
        end else if (!r[m_owner]) begin
            w = pick(r, m_owner);
            if (w >= 0) take(w);
            else        m_owner = -1;
        end else if (LIMIT_ON && m_tenure == HOLD_MAX) begin
            take(pick(r, m_owner));
            m_timeout = 1'b1;
        end else begin
            m_tenure++;
        end
    endfunction

    function automatic logic [7:0] m_grant();
        return (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] eg,
                               input logic [2:0] es, input logic eb,
                               input logic et);
        checks++;
        if (grant !== eg || select !== es || busy !== eb || timeout !== et) begin
            failures++;
            $display("[TB] FAIL %s at %0t: grant=%h select=%0d busy=%b timeout=%b, required grant=%h select=%0d busy=%b timeout=%b",
                     name, $time, grant, select, busy, timeout, eg, es, eb, et);
        end
    endtask

    // Drive req, let one rising edge sample it, advance the model, and
    // leave the bench 1 ns after the edge so outputs can be read.
    task automatic applyStimulus(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'h00;
        #1;
        checkOutput("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] r;

        // Wrap-around, single requester, handover and search-order vectors.
        vecs[0]  = '{8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[3]  = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[4]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[5]  = '{8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[6]  = '{8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[7]  = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[8]  = '{8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[9]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        vecs[10] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        vecs[11] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        vecs[12] = '{8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
        vecs[13] = '{8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[14] = '{8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[15] = '{8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
        vecs[16] = '{8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
        vecs[17] = '{8'h00, 8'h00, 3'd5, 1'b0, 1'b0};
        vecs[18] = '{8'h41, 8'h40, 3'd6, 1'b1, 1'b0};
        vecs[19] = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[20] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[21] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[22] = '{8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[23] = '{8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[24] = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[25] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        model_reset();
        doReset();

        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i].req);
            checkOutput($sformatf("vector_%0d", i), vecs[i].grant, vecs[i].sel,
                        vecs[i].busy, vecs[i].tmo);
        end

        // Asynchronous reset in the middle of a grant cycle.
        doReset();
        applyStimulus(8'h10);
        checkOutput("pre_reset_grant", 8'h10, 3'd4, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_midcycle", 8'h00, 3'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        model_reset();
        applyStimulus(8'h01);
        checkOutput("post_reset_grant", 8'h01, 3'd0, 1'b1, 1'b0);

`ifdef MUX_ARB_TIMEOUT_EN
        // Every requester active: the grant rotates every HOLD_MAX cycles.
        doReset();
        for (int c = 0; c < 8 * HOLD_MAX + HOLD_MAX; c++) begin
            applyStimulus(8'hFF);
            checkOutput($sformatf("rotate_ff_c%0d", c),
                        8'(8'h01 << ((c / HOLD_MAX) % 8)),
                        3'((c / HOLD_MAX) % 8), 1'b1,
                        (c > 0 && c % HOLD_MAX == 0));
        end
        // A lone requester is re-granted at each limit, with a pulse every time.
        doReset();
        for (int c = 0; c < 3 * HOLD_MAX + 1; c++) begin
            applyStimulus(8'h04);
            checkOutput($sformatf("lone_hold_c%0d", c), 8'h04, 3'd2, 1'b1,
                        (c > 0 && c % HOLD_MAX == 0));
        end
`else
        // Without the limit, the first owner keeps the mux for good.
        doReset();
        for (int c = 0; c < 100; c++) begin
            applyStimulus(8'hFF);
            checkOutput($sformatf("no_limit_ff_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
`endif

        // Random request traffic compared against the behavioural model.
        doReset();
        r = 8'h00;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       r = 8'($urandom_range(0, 255));
                1:       r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
                2:       if (m_owner >= 0) r[m_owner] = 1'b0;
                default: r = r;
            endcase
            applyStimulus(r);
            checkOutput($sformatf("random_c%0d", c), m_grant(), m_sel,
                        (m_owner >= 0), m_timeout);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
